karatsuba_mul_8_seq: RTL and testbench
======================================

KARATSUBA_MUL_8_SEQ -- requirements
Module: karatsuba_mul_8_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-004 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-005 The block SHALL have port a, input, 8 bits: multiplicand, unsigned.
REQ-006 The block SHALL have port b, input, 8 bits: multiplier, unsigned.
REQ-007 The block SHALL have port out_valid, output, 1 bit: c holds a finished product.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer takes c.
REQ-009 The block SHALL have port c, output, 16 bits: unsigned product a*b.
REQ-010 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-011 The block SHALL time-multiplex exactly one instance of the existing 4x4 combinational karatsuba_mul_4 to form the 8x8 product.
REQ-012 The FSM SHALL have three states, IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of in_ready.
REQ-013 In IDLE, when in_valid and in_ready are both 1 at a clock edge, the block SHALL latch a and b, clear the 16-bit accumulator, set the 2-bit step counter to 0, and enter CALC.
REQ-014 In CALC, step k SHALL feed the 4x4 multiplier with the following operand nibbles and add the 8-bit result, shifted as listed, into the accumulator:
- k=0: a[3:0], b[3:0], shift 0.
- k=1: a[7:4], b[3:0], shift 4.
- k=2: a[3:0], b[7:4], shift 4.
- k=3: a[7:4], b[7:4], shift 8.
REQ-015 Accumulator additions SHALL be 16-bit unsigned with the carry-out discarded; the final sum SHALL never exceed 0xFE01.
REQ-016 After the step-3 accumulation edge, the FSM SHALL enter DONE; out_valid SHALL rise exactly 4 clock edges after the accept edge.
REQ-017 c SHALL be driven directly from the accumulator register and SHALL hold stable in DONE until out_valid and out_ready are both 1.
REQ-018 In DONE, when out_ready is 1, the FSM SHALL return to IDLE on the next edge; out_valid SHALL be 1 only in DONE.
REQ-019 A new operand pair SHALL NOT be accepted in the same cycle as the out_valid/out_ready handshake, because in_ready is 0 in DONE; minimum issue interval is therefore 6 cycles.
REQ-020 Changes on a and b after the accept edge SHALL NOT affect the product in flight.

Reset
REQ-021 While rst is 1, the block SHALL hold these values:
- state = IDLE, in_ready = 1, busy = 0, out_valid = 0.
- c = 0x0000, step counter = 0, latched operands = 0.
REQ-022 Asserting rst mid-CALC or mid-DONE SHALL abort the operation immediately; the partial result SHALL be discarded and never appear on c with out_valid set.

Configuration
REQ-023 With macro KMUL8_ZERO_SKIP_EN defined, an accepted pair where a==0 or b==0 SHALL go from IDLE directly to DONE, with c=0x0000 and out_valid set 1 edge after accept.
REQ-024 Without KMUL8_ZERO_SKIP_EN, zero operands SHALL take the full 4-step CALC path, giving the latency in REQ-016.

Verification
REQ-025 Accept a=0x12, b=0x34 with out_ready=1 -> out_valid rises 4 edges later with c=0x03A8, then in_ready returns to 1 on the following edge.
REQ-026 Accept a=0xFF, b=0xFF -> c=0xFE01; accept a=0xA5, b=0x3C -> c=0x26AC.
REQ-027 Hold out_ready=0 for 3 cycles in DONE while toggling a, b and in_valid -> c, out_valid and in_ready stay unchanged; then raise out_ready -> IDLE on the next edge.
REQ-028 Assert rst for 1 cycle at CALC step 2 of a=0x77, b=0x99 -> outputs go to reset values; out_valid is never set; the next pair, a=0x03, b=0x05, yields c=0x000F.
REQ-029 Accept a=0x00, b=0x5A:
- With KMUL8_ZERO_SKIP_EN, c=0x0000 and out_valid rise 1 edge after accept.
- Without it, c=0x0000 and out_valid rise 4 edges after accept.

Source files
------------

// File: rtl/karatsuba_mul_8_seq.sv
// -----------------------------------------------------------------------------
// karatsuba_mul_8_seq
//
// Sequential 8x8 unsigned multiplier. It reuses one combinational 4x4
// Karatsuba multiplier (karatsuba_mul_4) over four cycles, one nibble pair per
// cycle, and accumulates the shifted partial products into a 16-bit register.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   in_valid   an operand pair is offered on a/b
//   in_ready   block can accept a pair (1 only in IDLE)
//   a, b       8-bit unsigned operands
//   out_valid  c holds a finished product (1 only in DONE)
//   out_ready  consumer takes c
//   c          16-bit unsigned product, driven straight from the accumulator
//   busy       FSM is not in IDLE (inverse of in_ready)
//
// Configuration
//   KMUL8_ZERO_SKIP_EN  when defined, a pair with a zero operand skips the four
//                       multiply steps and reports c = 0 one edge after accept.
// -----------------------------------------------------------------------------

module karatsuba_mul_4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);
  // Split each nibble into 2-bit halves: x = xh*4 + xl.
  logic [1:0] xh, xl, yh, yl;
  logic [2:0] xs, ys;
  logic [3:0] z2, z0;
  logic [5:0] zm, z1;

  assign xh = x[3:2];
  assign xl = x[1:0];
  assign yh = y[3:2];
  assign yl = y[1:0];

  assign xs = {1'b0, xh} + {1'b0, xl};
  assign ys = {1'b0, yh} + {1'b0, yl};

  assign z2 = {2'b00, xh} * {2'b00, yh};
  assign z0 = {2'b00, xl} * {2'b00, yl};
  assign zm = {3'b000, xs} * {3'b000, ys};

  // Middle term xh*yl + xl*yh recovered from the single cross product.
  assign z1 = zm - {2'b00, z2} - {2'b00, z0};

  assign p = {z2, 4'b0000} + {z1, 2'b00} + {4'b0000, z0};
endmodule

module karatsuba_mul_8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] c,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  a_q, b_q;
  logic [15:0] acc;
  logic [1:0]  step;
`ifdef KMUL8_ZERO_SKIP_EN
  logic        zero_q;
`endif

  logic [3:0]  nib_x, nib_y;
  logic [7:0]  prod4;
  logic [15:0] partial;
  logic [15:0] acc_sum;

  // step[0] selects the high nibble of a, step[1] the high nibble of b, which
  // yields the k=0..3 operand order a_lo*b_lo, a_hi*b_lo, a_lo*b_hi, a_hi*b_hi.
  assign nib_x = step[0] ? a_q[7:4] : a_q[3:0];
  assign nib_y = step[1] ? b_q[7:4] : b_q[3:0];

  karatsuba_mul_4 u_mul4 (
    .x (nib_x),
    .y (nib_y),
    .p (prod4)
  );

  // NOTE: every signal written in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    partial = {8'h00, prod4};
    case (step)
      2'd0:    partial = {8'h00, prod4};
      2'd1,
      2'd2:    partial = {4'h0, prod4, 4'h0};
      default: partial = {prod4, 8'h00};
    endcase
  end

  // Carry-out is discarded; the true product never exceeds 0xFE01 anyway.
  assign acc_sum = acc + partial;

  assign c = acc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      acc       <= 16'h0000;
      step      <= 2'd0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
`ifdef KMUL8_ZERO_SKIP_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            acc      <= 16'h0000;
            step     <= 2'd0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef KMUL8_ZERO_SKIP_EN
            zero_q   <= (a == 8'h00) || (b == 8'h00);
`endif
          end
        end

        CALC: begin
`ifdef KMUL8_ZERO_SKIP_EN
          // Zero operand: skip all multiply steps; acc is already 0.
          if (zero_q) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else
`endif
          begin
            acc  <= acc_sum;
            step <= step + 2'd1;
            if (step == 2'd3) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mul_8_seq.sv
// -----------------------------------------------------------------------------
// tb_karatsuba_mul_8_seq
//
// Directed self-checking bench for karatsuba_mul_8_seq. Inputs are driven and
// outputs sampled on the falling clock edge; the DUT acts on rising edges.
// -----------------------------------------------------------------------------

module tb_karatsuba_mul_8_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c;
  logic        busy;

  int checks;
  int failures;

`ifdef KMUL8_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 4;
`endif
  localparam int WAIT_LIMIT = 20;

  karatsuba_mul_8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer a pair at a falling edge, let the next rising edge accept it, then
  // scramble a/b and count falling edges until out_valid (bounded).
  task automatic issue_and_wait(input logic [7:0] x, input logic [7:0] y,
                                output int lat, output logic [15:0] prod);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
    lat = 0;
    while (!out_valid && lat < WAIT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    prod = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || c !== 16'h0000) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b busy=%b out_valid=%b c=%h, required 1 0 0 0000",
               in_ready, busy, out_valid, c);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] prod;
    // Hand-run latency check for 0x12 * 0x34 = 0x03A8.
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'hEE;
    b = 8'hCB;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL calc_flags: in_ready=%b busy=%b out_valid=%b, required 0 1 0",
               in_ready, busy, out_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_valid: out_valid=%b after 3 edges, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || c !== 16'h03A8) begin
      failures++;
      $display("FAIL basic_product: out_valid=%b c=%h after 4 edges, required 1 03a8",
               out_valid, c);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL return_idle: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end

    issue_and_wait(8'hFF, 8'hFF, lat, prod);
    checks++;
    if (lat !== 4 || prod !== 16'hFE01) begin
      failures++;
      $display("FAIL max_product: latency=%0d c=%h, required 4 fe01", lat, prod);
    end
    @(negedge clk);
    issue_and_wait(8'hA5, 8'h3C, lat, prod);
    checks++;
    if (lat !== 4 || prod !== 16'h26AC) begin
      failures++;
      $display("FAIL a5x3c: latency=%0d c=%h, required 4 26ac", lat, prod);
    end
    @(negedge clk);
  endtask

  task automatic test_patterns();
    logic [7:0]  va [4];
    logic [7:0]  vb [4];
    logic [15:0] vc [4];
    int lat;
    logic [15:0] prod;
    va[0] = 8'h0F; vb[0] = 8'hF0; vc[0] = 16'h0E10;
    va[1] = 8'h80; vb[1] = 8'h02; vc[1] = 16'h0100;
    va[2] = 8'h01; vb[2] = 8'hFF; vc[2] = 16'h00FF;
    va[3] = 8'hC3; vb[3] = 8'h5E; vc[3] = 16'h479A;
    for (int i = 0; i < 4; i++) begin
      issue_and_wait(va[i], vb[i], lat, prod);
      checks++;
      if (lat !== 4 || prod !== vc[i]) begin
        failures++;
        $display("FAIL pattern_%0d: %h*%h latency=%0d c=%h, required 4 %h",
                 i, va[i], vb[i], lat, prod, vc[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] prod;
    out_ready = 1'b0;
    issue_and_wait(8'h21, 8'h43, lat, prod);
    checks++;
    if (lat !== 4 || prod !== 16'h08A3) begin
      failures++;
      $display("FAIL bp_product: latency=%0d c=%h, required 4 08a3", lat, prod);
    end
    for (int i = 0; i < 3; i++) begin
      a = 8'h55 ^ 8'(i);
      b = 8'hAA ^ 8'(i);
      in_valid = i[0];
      @(negedge clk);
      checks++;
      if (c !== 16'h08A3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: c=%h out_valid=%b in_ready=%b, required 08a3 1 0",
                 i, c, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [15:0] prod;
    bit seen_valid;
    @(negedge clk);
    a = 8'h77;
    b = 8'h99;
    in_valid = 1'b1;
    @(posedge clk);                 // accept
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);      // steps 0 and 1 done; step counter is 2
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || c !== 16'h0000) begin
      failures++;
      $display("FAIL abort_reset: in_ready=%b busy=%b out_valid=%b c=%h, required 1 0 0 0000",
               in_ready, busy, out_valid, c);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_valid: out_valid seen=%b, required 0", seen_valid);
    end
    issue_and_wait(8'h03, 8'h05, lat, prod);
    checks++;
    if (lat !== 4 || prod !== 16'h000F) begin
      failures++;
      $display("FAIL after_abort: latency=%0d c=%h, required 4 000f", lat, prod);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat;
    logic [15:0] prod;
    issue_and_wait(8'h00, 8'h5A, lat, prod);
    checks++;
    if (lat !== ZERO_LAT || prod !== 16'h0000) begin
      failures++;
      $display("FAIL zero_operand: latency=%0d c=%h, required %0d 0000", lat, prod, ZERO_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    // in_valid held high: the second pair is taken the first cycle back in IDLE.
    @(negedge clk);
    a = 8'h19;
    b = 8'h0B;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < WAIT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1 || c !== 16'h0113) begin
      failures++;
      $display("FAIL b2b_first: out_valid=%b c=%h, required 1 0113", out_valid, c);
    end
    a = 8'h07;
    b = 8'h0D;
    gap = 0;
    @(negedge clk);
    gap++;
    while (!out_valid && gap < WAIT_LIMIT) begin
      @(negedge clk);
      gap++;
    end
    in_valid = 1'b0;
    checks++;
    if (gap !== 6 || c !== 16'h005B) begin
      failures++;
      $display("FAIL b2b_second: interval=%0d c=%h, required 6 005b", gap, c);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_reset_abort();
    test_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
